// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit channel: FIFO status bit masks,
// serialiser state encodings and the smallest usable baud divisor.
package uart_tx_fifo_pkg;

    localparam logic [3:0] FIFO_EMPTY  = 4'b0001;
    localparam logic [3:0] FIFO_AEMPTY = 4'b0010;
    localparam logic [3:0] FIFO_AFULL  = 4'b0100;
    localparam logic [3:0] FIFO_FULL   = 4'b1000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy/status and a sticky overflow flag.
// The head entry is always presented on rdata; pop advances it.
module uart_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               status,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic [3:0]        status_next;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (status & FIFO_FULL) != 4'b0000;
    assign empty   = (status & FIFO_EMPTY) != 4'b0000;
    // A write while full still lands when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;

        status_next = 4'b0000;
        if (count_next == '0)        status_next = status_next | FIFO_EMPTY;
        if (count_next <= AEMPTY_C)  status_next = status_next | FIFO_AEMPTY;
        if (count_next >= AFULL_C)   status_next = status_next | FIFO_AFULL;
        if (count_next == DEPTH_C)   status_next = status_next | FIFO_FULL;
    end

    // NOTE: storage has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge Clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            status   <= FIFO_EMPTY | FIFO_AEMPTY;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            status <= status_next;
            if (push && full && !do_pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit channel: write-side FIFO feeding a serialiser whose divisor,
// parity and stop-bit settings are sampled once per frame.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int DIV_W     = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [DATA_W-1:0]        fwdata,
    input  logic                     fwrite,
    output logic [3:0]               fwstatus,
    output logic [$clog2(DEPTH):0]   fcount,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     two_stop,
    input  logic                     ovf_clr,
    output logic                     overflow,
    output logic                     busy,
    output logic                     TX
);

    localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_W - 1);

    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [2:0]        state;
    logic [2:0]        state_next;
    logic              load;
    logic [DIV_W-1:0]  eff_div;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic              bit_end;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        bit_idx;
    logic              stop_idx;
    logic              par_q;
    logic              par_en_q;
    logic              two_stop_q;
    logic              tx_bit;

    uart_sync_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (fwrite),
        .wdata    (fwdata),
        .pop      (fifo_pop),
        .ovf_clr  (ovf_clr),
        .rdata    (fifo_rdata),
        .count    (fcount),
        .status   (fwstatus),
        .overflow (overflow)
    );

    assign fifo_empty = (fwstatus & FIFO_EMPTY) != 4'b0000;
    assign eff_div    = (baud_div < MIN_DIV_W) ? MIN_DIV_W : baud_div;
    assign bit_end    = (cnt == '0);

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE:
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load       = 1'b1;
                    state_next = ST_START;
                end
            ST_START:
                if (bit_end) state_next = ST_DATA;
            ST_DATA:
                if (bit_end && bit_idx == LAST_BIT)
                    state_next = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY:
                if (bit_end) state_next = ST_STOP;
            ST_STOP:
                // Chaining straight into the next START keeps frames gap-free.
                if (bit_end && (stop_idx || !two_stop_q)) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            ST_START:  tx_bit = 1'b0;
            ST_DATA:   tx_bit = shreg[0];
            ST_PARITY: tx_bit = par_q;
            default:   tx_bit = 1'b1;
        endcase
    end

    // TX and busy are registered copies of the state, so both trail it by one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            div_q      <= MIN_DIV_W;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            TX         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            TX    <= tx_bit;
            busy  <= (state != ST_IDLE);
            if (load) begin
                shreg      <= fifo_rdata;
                par_q      <= (^fifo_rdata) ^ parity_odd;
                par_en_q   <= parity_en;
                two_stop_q <= two_stop;
                div_q      <= eff_div;
                cnt        <= eff_div - 1'b1;
                bit_idx    <= '0;
                stop_idx   <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (bit_end) begin
                    cnt <= div_q - 1'b1;
                    if (state == ST_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (state == ST_STOP) stop_idx <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes push expected frames into a queue;
// a TX monitor decodes each frame and compares it against the queue head.
module tb_uart_tx_fifo;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  fwdata;
    logic        fwrite;
    logic [3:0]  fwstatus;
    logic [3:0]  fcount;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic        ovf_clr;
    logic        overflow;
    logic        busy;
    logic        tx;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         pval;
        bit         ts;
        int         div;
        longint     start;
        bit         b2b;
        bit         abort;
    } item_t;

    item_t  exp_q[$];
    int     n_checks = 0;
    int     n_err    = 0;
    longint cyc      = 0;
    bit     mon_busy = 1'b0;

    uart_tx_fifo dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .fwdata     (fwdata),
        .fwrite     (fwrite),
        .fwstatus   (fwstatus),
        .fcount     (fcount),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
        .busy       (busy),
        .TX         (tx)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input bit pen, input bit pval, input bit ts,
                            input int div, input longint start, input bit b2b, input bit abort);
        item_t it;
        it.data = d; it.pen = pen; it.pval = pval; it.ts = ts;
        it.div = div; it.start = start; it.b2b = b2b; it.abort = abort;
        exp_q.push_back(it);
    endtask

    // Drives one write over the next rising edge; returns #1 after that edge.
    task automatic wr(input logic [7:0] d);
        fwdata = d;
        fwrite = 1'b1;
        @(posedge Clk); #1;
        fwrite = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
            @(posedge Clk); #1;
            k++;
        end
        check("drain_queue", longint'(exp_q.size()), 0);
    endtask

    // Monitor: detects a start bit, samples every cycle of the frame, checks bit
    // values, exact bit time, start latency and back-to-back spacing.
    initial begin
        item_t      it;
        int         nb;
        logic [11:0] rx;
        logic [11:0] ex;
        bit         glitch;
        bit         aborted;
        longint     last_end = -10;
        forever begin
            @(negedge Clk);
            if (Reset === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", longint'(tx), 1);
                end else begin
                    it = exp_q.pop_front();
                    mon_busy = 1'b1;
                    if (it.start >= 0) check("start_latency", cyc, it.start);
                    if (it.b2b) check("b2b_gap", cyc, last_end + 1);
                    nb = 1 + 8 + int'(it.pen) + 1 + int'(it.ts);
                    ex = '1;
                    ex[0] = 1'b0;
                    for (int i = 0; i < 8; i++) ex[1 + i] = it.data[i];
                    if (it.pen) ex[9] = it.pval;
                    rx = '1;
                    glitch = 1'b0;
                    aborted = 1'b0;
                    for (int i = 0; i < nb * it.div; i++) begin
                        if (i > 0) @(negedge Clk);
                        if (Reset !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (i % it.div == 0) rx[i / it.div] = tx;
                        else if (tx !== rx[i / it.div]) glitch = 1'b1;
                    end
                    check("frame_aborted", longint'(aborted), longint'(it.abort));
                    if (!aborted && !it.abort) begin
                        check("frame_bits", longint'(rx), longint'(ex));
                        check("bit_time", longint'(glitch), 0);
                    end
                    last_end = cyc;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        longint n;
        longint e1;
        logic [3:0] exp_cnt  [10] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
        logic [3:0] exp_stat [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                      4'b0000, 4'b0100, 4'b0100, 4'b1100, 4'b1100};

        // Reset with a write strobe held high: nothing may be accepted.
        Reset = 1'b0; fwrite = 1'b1; fwdata = 8'hFF; baud_div = 16'd4;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; ovf_clr = 1'b0;
        step(3);
        check("rst_tx", longint'(tx), 1);
        check("rst_status", longint'(fwstatus), 4'b0011);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_count", longint'(fcount), 0);
        fwrite = 1'b0;
        @(negedge Clk) Reset = 1'b1;
        step(2);

        // Single 8N1 frame of 0x5A at divisor 4: TX low two edges after the write.
        wr(8'h5A);
        n = cyc;
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0, 4, n + 2, 1'b0, 1'b0);
        check("one_count", longint'(fcount), 1);
        check("one_status", longint'(fwstatus), 4'b0010);
        check("busy_n0", longint'(busy), 0);
        step(1);
        check("pop_count", longint'(fcount), 0);
        check("busy_n1", longint'(busy), 0);
        step(1);
        check("busy_n2", longint'(busy), 1);
        while (cyc < n + 41) step(1);
        check("busy_last_stop", longint'(busy), 1);
        step(1);
        check("busy_after_stop", longint'(busy), 0);
        drain(200);

        // Even parity (bit 0) with two stop bits, then odd parity (bit 1).
        parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
        wr(8'h5A);
        push_exp(8'h5A, 1'b1, 1'b0, 1'b1, 4, cyc + 2, 1'b0, 1'b0);
        drain(200);
        step(3);
        parity_odd = 1'b1; two_stop = 1'b0;
        wr(8'h5A);
        push_exp(8'h5A, 1'b1, 1'b1, 1'b0, 4, cyc + 2, 1'b0, 1'b0);
        drain(200);
        step(3);

        // Fill while the first frame crawls at divisor 1000.
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; baud_div = 16'd1000;
        e1 = 0;
        for (int i = 0; i < 10; i++) begin
            wr(8'(i + 1));
            if (i == 0) begin
                e1 = cyc;
                push_exp(8'h01, 1'b0, 1'b0, 1'b0, 1000, e1 + 2, 1'b0, 1'b0);
            end else if (i < 9) begin
                push_exp(8'(i + 1), 1'b0, 1'b0, 1'b0, 4, -1, 1'b1, 1'b0);
            end
            check("fill_count", longint'(fcount), longint'(exp_cnt[i]));
            check("fill_status", longint'(fwstatus), longint'(exp_stat[i]));
            check("fill_overflow", longint'(overflow), (i == 9) ? 1 : 0);
        end

        // Sticky overflow: clear, then clear coinciding with a new drop (set wins).
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        check("ovf_cleared", longint'(overflow), 0);
        ovf_clr = 1'b1; wr(8'h0C); ovf_clr = 1'b0;
        check("ovf_set_wins", longint'(overflow), 1);
        check("drop_count", longint'(fcount), 8);
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        check("ovf_cleared2", longint'(overflow), 0);
        baud_div = 16'd4;

        // Write on the edge where the 0x01 frame ends and 0x02 is popped.
        while (cyc < e1 + 1 + 9999) step(1);
        wr(8'h0B);
        push_exp(8'h0B, 1'b0, 1'b0, 1'b0, 4, -1, 1'b1, 1'b0);
        check("popwr_count", longint'(fcount), 8);
        check("popwr_status", longint'(fwstatus), 4'b1100);
        check("popwr_overflow", longint'(overflow), 0);
        drain(12000);
        step(3);

        // Reset in the middle of the data bits discards the frame and the FIFO.
        wr(8'hA5);
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0, 4, cyc + 2, 1'b0, 1'b1);
        wr(8'h3C);
        step(12);
        Reset = 1'b0;
        #1;
        check("midrst_tx", longint'(tx), 1);
        check("midrst_status", longint'(fwstatus), 4'b0011);
        check("midrst_count", longint'(fcount), 0);
        check("midrst_busy", longint'(busy), 0);
        step(3);
        @(negedge Clk) Reset = 1'b1;
        step(30);
        check("post_rst_tx", longint'(tx), 1);
        drain(10);

        // Divisors 0 and 1 both clamp to two cycles per bit.
        baud_div = 16'd0;
        wr(8'h96);
        push_exp(8'h96, 1'b0, 1'b0, 1'b0, 2, cyc + 2, 1'b0, 1'b0);
        drain(100);
        step(3);
        baud_div = 16'd1; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
        wr(8'hC3);
        push_exp(8'hC3, 1'b1, 1'b1, 1'b1, 2, cyc + 2, 1'b0, 1'b0);
        drain(100);
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
